// File: rtl/mesi_snoop_agent.sv
// Per-core MESI snoop responder: tracks line states written by the L1 and answers
// directory snoops, forcing a writeback through the L1 when the line is Modified.
module mesi_snoop_agent #(
   parameter int         ENTRIES = 8,
   parameter logic [1:0] CORE_ID = 2'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snp_valid_i,
   output logic        snp_ready_o,
   input  logic [63:0] snp_addr_i,
   input  logic        snp_inval_i,
   output logic        snp_resp_valid_o,
   input  logic        snp_resp_ready_i,
   output logic        snp_resp_hit_o,
   output logic        snp_resp_dirty_o,
   output logic [1:0]  snp_resp_state_o,
   output logic [1:0]  snp_resp_src_o,
   output logic        wb_req_valid_o,
   input  logic        wb_req_ready_i,
   output logic [63:0] wb_addr_o,
   input  logic        wb_done_i,
   input  logic        upd_valid_i,
   output logic        upd_ready_o,
   input  logic [63:0] upd_addr_i,
   input  logic [1:0]  upd_state_i,
   output logic        busy_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b11;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, RESP} fsm_e;

   fsm_e              fsm_q, fsm_d;
   logic [57:0]       tag_q [ENTRIES];
   logic [57:0]       tag_d [ENTRIES];
   logic [1:0]        st_q  [ENTRIES];
   logic [1:0]        st_d  [ENTRIES];
   logic [IDX_W-1:0]  rr_q, rr_d;
   logic [57:0]       snp_tag_q, snp_tag_d;
   logic              inval_q, inval_d;
   logic              hit_q, hit_d;
   logic [1:0]        prior_q, prior_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   logic              snp_match;
   logic [IDX_W-1:0]  snp_idx;
   logic [1:0]        snp_state;
   logic              upd_match;
   logic [IDX_W-1:0]  upd_idx;
   logic              free_found;
   logic [IDX_W-1:0]  free_idx;
   logic [57:0]       upd_tag;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{snp_addr_i[5:0], upd_addr_i[5:0]};
   assign upd_tag = upd_addr_i[63:6];

   // Table search: snoop tag match, update tag match, and lowest free slot.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      snp_match  = 1'b0;
      snp_idx    = '0;
      snp_state  = ST_I;
      upd_match  = 1'b0;
      upd_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (st_q[i] != ST_I && tag_q[i] == snp_tag_q) begin
            snp_match = 1'b1;
            snp_idx   = IDX_W'(i);
            snp_state = st_q[i];
         end
         if (st_q[i] != ST_I && tag_q[i] == upd_tag) begin
            upd_match = 1'b1;
            upd_idx   = IDX_W'(i);
         end
         if (st_q[i] == ST_I) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      tag_d     = tag_q;
      st_d      = st_q;
      rr_d      = rr_q;
      snp_tag_d = snp_tag_q;
      inval_d   = inval_q;
      hit_d     = hit_q;
      prior_d   = prior_q;
      idx_d     = idx_q;
      case (fsm_q)
         IDLE: begin
            if (upd_valid_i) begin
               if (upd_match) begin
                  st_d[upd_idx] = upd_state_i;
               end else if (upd_state_i != ST_I) begin
                  if (free_found) begin
                     tag_d[free_idx] = upd_tag;
                     st_d[free_idx]  = upd_state_i;
                  end else begin
                     tag_d[rr_q] = upd_tag;
                     st_d[rr_q]  = upd_state_i;
                     rr_d        = rr_q + 1'b1;
                  end
               end
            end
            if (snp_valid_i) begin
               snp_tag_d = snp_addr_i[63:6];
               inval_d   = snp_inval_i;
               fsm_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            hit_d   = snp_match;
            prior_d = snp_match ? snp_state : ST_I;
            idx_d   = snp_idx;
            if (snp_match && snp_state == ST_M) begin
               fsm_d = WB_REQ;
            end else begin
               if (snp_match) st_d[snp_idx] = inval_q ? ST_I : ST_S;
               fsm_d = RESP;
            end
         end
         WB_REQ: begin
            if (wb_req_ready_i) fsm_d = WB_WAIT;
         end
         WB_WAIT: begin
            // The dirty line's state is only released once its data is safe downstream.
            if (wb_done_i) begin
               st_d[idx_q] = inval_q ? ST_I : ST_S;
               fsm_d       = RESP;
            end
         end
         RESP: begin
            if (snp_resp_ready_i) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the state table is reset explicitly; stale states after reset would fake hits.
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            st_q[i]  <= ST_I;
         end
         fsm_q     <= IDLE;
         rr_q      <= '0;
         snp_tag_q <= '0;
         inval_q   <= 1'b0;
         hit_q     <= 1'b0;
         prior_q   <= ST_I;
         idx_q     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         tag_q     <= tag_d;
         st_q      <= st_d;
         fsm_q     <= fsm_d;
         rr_q      <= rr_d;
         snp_tag_q <= snp_tag_d;
         inval_q   <= inval_d;
         hit_q     <= hit_d;
         prior_q   <= prior_d;
         idx_q     <= idx_d;
      end
   end

   assign snp_ready_o      = (fsm_q == IDLE);
   assign upd_ready_o      = (fsm_q == IDLE);
   assign busy_o           = (fsm_q != IDLE);
   assign wb_req_valid_o   = (fsm_q == WB_REQ);
   assign wb_addr_o        = (fsm_q == WB_REQ) ? {snp_tag_q, 6'b0} : 64'd0;
   assign snp_resp_valid_o = (fsm_q == RESP);
   assign snp_resp_hit_o   = (fsm_q == RESP) & hit_q;
   assign snp_resp_dirty_o = (fsm_q == RESP) & (prior_q == ST_M);
   assign snp_resp_state_o = (fsm_q == RESP) ? prior_q : ST_I;
   assign snp_resp_src_o   = (fsm_q == RESP) ? CORE_ID : 2'b00;

endmodule

// File: tb/tb_mesi_snoop_agent.sv
// Directed bench for mesi_snoop_agent: latency, writeback handshake, replacement and reset abort.
module tb_mesi_snoop_agent;

   localparam logic [1:0] CID = 2'd2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        snp_valid_i = 1'b0;
   logic        snp_ready_o;
   logic [63:0] snp_addr_i = '0;
   logic        snp_inval_i = 1'b0;
   logic        snp_resp_valid_o;
   logic        snp_resp_ready_i = 1'b0;
   logic        snp_resp_hit_o;
   logic        snp_resp_dirty_o;
   logic [1:0]  snp_resp_state_o;
   logic [1:0]  snp_resp_src_o;
   logic        wb_req_valid_o;
   logic        wb_req_ready_i = 1'b0;
   logic [63:0] wb_addr_o;
   logic        wb_done_i = 1'b0;
   logic        upd_valid_i = 1'b0;
   logic        upd_ready_o;
   logic [63:0] upd_addr_i = '0;
   logic [1:0]  upd_state_i = '0;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mesi_snoop_agent #(.ENTRIES(8), .CORE_ID(CID)) dut (
      .clk(clk), .rst(rst),
      .snp_valid_i(snp_valid_i), .snp_ready_o(snp_ready_o),
      .snp_addr_i(snp_addr_i), .snp_inval_i(snp_inval_i),
      .snp_resp_valid_o(snp_resp_valid_o), .snp_resp_ready_i(snp_resp_ready_i),
      .snp_resp_hit_o(snp_resp_hit_o), .snp_resp_dirty_o(snp_resp_dirty_o),
      .snp_resp_state_o(snp_resp_state_o), .snp_resp_src_o(snp_resp_src_o),
      .wb_req_valid_o(wb_req_valid_o), .wb_req_ready_i(wb_req_ready_i),
      .wb_addr_o(wb_addr_o), .wb_done_i(wb_done_i),
      .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
      .upd_addr_i(upd_addr_i), .upd_state_i(upd_state_i),
      .busy_o(busy_o)
   );

   // {valid, hit, dirty, state, src}
   logic [6:0] resp_vec;
   assign resp_vec = {snp_resp_valid_o, snp_resp_hit_o, snp_resp_dirty_o,
                      snp_resp_state_o, snp_resp_src_o};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      snp_valid_i = 1'b0; snp_resp_ready_i = 1'b0; wb_req_ready_i = 1'b0;
      wb_done_i = 1'b0; upd_valid_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_update(input logic [63:0] a, input logic [1:0] s);
      upd_valid_i = 1'b1; upd_addr_i = a; upd_state_i = s;
      tick();
      upd_valid_i = 1'b0;
   endtask

   task automatic start_snoop(input logic [63:0] a, input logic inval);
      snp_valid_i = 1'b1; snp_addr_i = a; snp_inval_i = inval;
      tick();
      snp_valid_i = 1'b0;
   endtask

   // Non-M snoop: response must be valid exactly two cycles after acceptance.
   task automatic snoop_expect(input string name, input logic [63:0] a, input logic inval,
                               input logic hit, input logic [1:0] st);
      start_snoop(a, inval);
      tick();
      checks++;
      if ({resp_vec, wb_req_valid_o} !== {1'b1, hit, 1'b0, st, CID, 1'b0}) begin
         errors++;
         $display("FAIL %s: resp+wb got %b expected %b", name,
                  {resp_vec, wb_req_valid_o}, {1'b1, hit, 1'b0, st, CID, 1'b0});
      end
      snp_resp_ready_i = 1'b1;
      tick();
      snp_resp_ready_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy got %b expected 0", name, busy_o);
      end
   endtask

   task automatic test_reset();
      reset_dut();
      checks++;
      if ({snp_ready_o, upd_ready_o, busy_o, resp_vec, wb_req_valid_o, wb_addr_o} !==
          {1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 64'd0}) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h",
                  {snp_ready_o, upd_ready_o, busy_o, resp_vec, wb_req_valid_o, wb_addr_o},
                  {1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 64'd0});
      end
   endtask

   task automatic test_downgrade();
      reset_dut();
      do_update(64'h1000, 2'b10);
      snoop_expect("downgrade_E", 64'h1000, 1'b0, 1'b1, 2'b10);
      snoop_expect("after_downgrade_S", 64'h1000, 1'b0, 1'b1, 2'b01);
      snoop_expect("inval_S", 64'h1000, 1'b1, 1'b1, 2'b01);
      snoop_expect("after_inval_miss", 64'h1000, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic test_writeback();
      reset_dut();
      wb_done_i = 1'b1;
      tick();
      wb_done_i = 1'b0;
      checks++;
      if ({busy_o, snp_resp_valid_o} !== 2'b00) begin
         errors++;
         $display("FAIL stray_done_idle: busy/resp got %b expected 00", {busy_o, snp_resp_valid_o});
      end
      do_update(64'h2040, 2'b11);
      start_snoop(64'h2040, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({wb_req_valid_o, wb_addr_o, snp_resp_valid_o} !== {1'b1, 64'h2040, 1'b0}) begin
            errors++;
            $display("FAIL wb_req_hold%0d: got %h expected %h", i,
                     {wb_req_valid_o, wb_addr_o, snp_resp_valid_o}, {1'b1, 64'h2040, 1'b0});
         end
         if (i == 3) wb_req_ready_i = 1'b1;
         tick();
      end
      wb_req_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({busy_o, wb_req_valid_o, snp_resp_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL wb_wait%0d: busy/wb/resp got %b expected 100", i,
                     {busy_o, wb_req_valid_o, snp_resp_valid_o});
         end
         if (i == 3) wb_done_i = 1'b1;
         tick();
      end
      wb_done_i = 1'b0;
      checks++;
      if (resp_vec !== {1'b1, 1'b1, 1'b1, 2'b11, CID}) begin
         errors++;
         $display("FAIL wb_resp: got %b expected %b", resp_vec, {1'b1, 1'b1, 1'b1, 2'b11, CID});
      end
      snp_resp_ready_i = 1'b1;
      tick();
      snp_resp_ready_i = 1'b0;
      snoop_expect("resnoop_miss", 64'h2040, 1'b1, 1'b0, 2'b00);
   endtask

   task automatic test_miss();
      reset_dut();
      snoop_expect("empty_miss", 64'h9999_0000, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic test_replacement();
      reset_dut();
      for (int i = 0; i < 8; i++) do_update(64'h10000 + 64'(i) * 64'h40, 2'b01);
      do_update(64'h20000, 2'b01);
      snoop_expect("evicted_entry0", 64'h10000, 1'b0, 1'b0, 2'b00);
      snoop_expect("ninth_line_hit", 64'h20000, 1'b0, 1'b1, 2'b01);
      snoop_expect("entry1_kept", 64'h10040, 1'b0, 1'b1, 2'b01);
      do_update(64'h20040, 2'b10);
      snoop_expect("evicted_entry1", 64'h10040, 1'b0, 1'b0, 2'b00);
      snoop_expect("entry2_kept", 64'h10080, 1'b0, 1'b1, 2'b01);
      snoop_expect("tenth_line_hit", 64'h20040, 1'b0, 1'b1, 2'b10);
   endtask

   task automatic test_same_cycle();
      reset_dut();
      upd_valid_i = 1'b1; upd_addr_i = 64'h3000; upd_state_i = 2'b11;
      snp_valid_i = 1'b1; snp_addr_i = 64'h3000; snp_inval_i = 1'b1;
      tick();
      upd_valid_i = 1'b0; snp_valid_i = 1'b0;
      checks++;
      if ({upd_ready_o, snp_ready_o, busy_o} !== 3'b001) begin
         errors++;
         $display("FAIL lookup_ready: upd/snp/busy got %b expected 001", {upd_ready_o, snp_ready_o, busy_o});
      end
      tick();
      checks++;
      if ({upd_ready_o, wb_req_valid_o, wb_addr_o} !== {1'b0, 1'b1, 64'h3000}) begin
         errors++;
         $display("FAIL same_cycle_wb: got %h expected %h",
                  {upd_ready_o, wb_req_valid_o, wb_addr_o}, {1'b0, 1'b1, 64'h3000});
      end
      wb_req_ready_i = 1'b1;
      tick();
      wb_req_ready_i = 1'b0;
      // An update offered while busy must not be taken.
      upd_valid_i = 1'b1; upd_addr_i = 64'h3000; upd_state_i = 2'b01;
      checks++;
      if (upd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL wb_wait_upd_ready: got %b expected 0", upd_ready_o);
      end
      wb_done_i = 1'b1;
      tick();
      wb_done_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({upd_ready_o, resp_vec} !== {1'b0, 1'b1, 1'b1, 1'b1, 2'b11, CID}) begin
            errors++;
            $display("FAIL resp_stable%0d: got %b expected %b", i,
                     {upd_ready_o, resp_vec}, {1'b0, 1'b1, 1'b1, 1'b1, 2'b11, CID});
         end
         if (i == 5) snp_resp_ready_i = 1'b1;
         tick();
      end
      snp_resp_ready_i = 1'b0;
      upd_valid_i = 1'b0;
      checks++;
      if ({upd_ready_o, snp_resp_valid_o} !== 2'b10) begin
         errors++;
         $display("FAIL back_to_idle: upd_ready/resp got %b expected 10", {upd_ready_o, snp_resp_valid_o});
      end
      snoop_expect("same_cycle_after_miss", 64'h3000, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic test_reset_abort();
      reset_dut();
      do_update(64'h4000, 2'b11);
      do_update(64'h5000, 2'b10);
      start_snoop(64'h4000, 1'b1);
      tick();
      wb_req_ready_i = 1'b1;
      tick();
      wb_req_ready_i = 1'b0;
      checks++;
      if ({busy_o, wb_req_valid_o} !== 2'b10) begin
         errors++;
         $display("FAIL in_wb_wait: busy/wb got %b expected 10", {busy_o, wb_req_valid_o});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy_o, resp_vec, wb_req_valid_o, wb_addr_o} !== {1'b0, 7'd0, 1'b0, 64'd0}) begin
         errors++;
         $display("FAIL abort_outputs: got %h expected %h",
                  {busy_o, resp_vec, wb_req_valid_o, wb_addr_o}, {1'b0, 7'd0, 1'b0, 64'd0});
      end
      wb_done_i = 1'b1;
      tick();
      wb_done_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({busy_o, snp_resp_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL late_done%0d: busy/resp got %b expected 00", i, {busy_o, snp_resp_valid_o});
         end
         tick();
      end
      snoop_expect("abort_cleared_E", 64'h5000, 1'b0, 1'b0, 2'b00);
      snoop_expect("abort_cleared_M", 64'h4000, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      test_reset();
      test_downgrade();
      test_writeback();
      test_miss();
      test_replacement();
      test_same_cycle();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
